// File: rtl/rr_encoder_8_3_pkg.sv
// ---------------------------------------------------------------------------
// rr_encoder_8_3_pkg
//   Shared definitions for the round-robin 8->3 priority encoder.
//   - RR_N / RR_W : default request count and index width
//   - rr_state_t  : grant FSM states (IDLE: nothing pending, HOLD: grant
//                   presented to the consumer)
// ---------------------------------------------------------------------------
package rr_encoder_8_3_pkg;

    localparam int RR_N = 8;
    localparam int RR_W = $clog2(RR_N);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rr_state_t;

endpackage

// File: rtl/rr_encoder_8_3_pick.sv
// ---------------------------------------------------------------------------
// rr_encoder_8_3_pick
//   Combinational circular first-one finder.
//   Returns the first set bit of v when scanning p, p+1, ..., N-1, 0, ..., p-1.
//   Ports:
//     v   in  N  candidate vector
//     p   in  W  scan start position
//     idx out W  index of the first set bit (0 when none)
//     any out 1  at least one bit of v is set
// ---------------------------------------------------------------------------
module rr_encoder_8_3_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] v,
    input  logic [W-1:0] p,
    output logic [W-1:0] idx,
    output logic         any
);

    // Rotating the doubled vector right by p puts position p at bit 0, so a
    // plain lowest-set-bit search on the low half is the circular scan.
    logic [N-1:0] rot;

    always_comb begin
        rot = N'({v, v} >> p);
        idx = '0;
        any = 1'b0;
        // Descending loop: the last hit written is the lowest rotated bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = p + W'(i);   // N is a power of two, so W-bit add wraps mod N
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_encoder_8_3.sv
// ---------------------------------------------------------------------------
// rr_encoder_8_3
//   Round-robin priority encoder with a valid/ready output handshake.
//   Captures one of the active request lines into a registered index, holds
//   it until the consumer takes it, then rotates priority past the granted
//   line. A still-pending request set is re-picked on the firing edge, so
//   grants can stream back-to-back.
//   Ports:
//     clk        in  1  clock, rising edge
//     resetn     in  1  synchronous active-low reset
//     flush      in  1  drop any pending grant, pointer kept
//     req        in  N  level request lines (multi-hot allowed)
//     out_valid  out 1  grant pending
//     out_ready  in  1  consumer accepts (fire = out_valid & out_ready)
//     out_idx    out W  granted line index
//     out_onehot out N  1 << out_idx while out_valid, else 0
//     ptr_o      out W  round-robin scan start pointer
// ---------------------------------------------------------------------------
module rr_encoder_8_3
    import rr_encoder_8_3_pkg::*;
#(
    parameter int N = RR_N,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [W-1:0] ptr_o
);

    rr_state_t    state, state_n;
    logic [W-1:0] ptr, ptr_n;
    logic [W-1:0] idx, idx_n;

    logic         fire;
    logic [W-1:0] after_idx;
    logic [N-1:0] rest_req;
    logic [W-1:0] cap_idx, rep_idx;
    logic         cap_any, rep_any;

    // Outputs come only from registers; req never reaches them combinationally.
    assign out_valid  = (state == ST_HOLD);
    assign out_idx    = idx;
    assign out_onehot = out_valid ? (N'(1) << idx) : '0;
    assign ptr_o      = ptr;

    assign fire      = out_valid & out_ready;
    assign after_idx = idx + W'(1);
    // Exclude the line being granted so a held request cannot win twice in a row.
    assign rest_req  = req & ~out_onehot;

    rr_encoder_8_3_pick #(.N(N), .W(W)) u_pick_capture (
        .v   (req),
        .p   (ptr),
        .idx (cap_idx),
        .any (cap_any)
    );

    rr_encoder_8_3_pick #(.N(N), .W(W)) u_pick_repick (
        .v   (rest_req),
        .p   (after_idx),
        .idx (rep_idx),
        .any (rep_any)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            ptr   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            idx   <= idx_n;
        end
    end

    // Edge priority: flush over fire over new capture.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = idx;
        if (flush) begin
            state_n = ST_IDLE;
        end else if (fire) begin
            ptr_n = after_idx;
            if (rep_any) begin
                idx_n = rep_idx;
            end else begin
                state_n = ST_IDLE;
            end
        end else if (state == ST_IDLE && cap_any) begin
            idx_n   = cap_idx;
            state_n = ST_HOLD;
        end
    end

endmodule
